duc_scale_clip: RTL

// Output stage of the DUC datapath, directly after the CORDIC frequency shifter.

---
 rtl/duc_pkg.sv | 39 +++
 rtl/duc_scale_clip_if.sv | 23 ++
 rtl/duc_scale_clip_lane.sv | 44 ++++
 rtl/duc_scale_clip.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/duc_pkg.sv
// rtl/duc_pkg.sv - shared DUC/DDC scaler constants, state type and round/saturate helper
package duc_pkg;

    localparam int SCALE_FRAC_BITS = 14;
    localparam int SCALE_UNITY     = 1 << SCALE_FRAC_BITS;

    typedef enum logic [0:0] {
        SC_IDLE    = 1'b0,
        SC_PENDING = 1'b1
    } scale_state_t;

    typedef struct packed {
        logic               clip;
        logic signed [31:0] value;
    } sat_t;

    // Round half toward +inf, then saturate to a signed width_out-bit range.
    function automatic sat_t sat_round(input logic signed [63:0] p,
                                       input int shift,
                                       input int width_out);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               res;
        r  = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (width_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width_out - 1));
        res.clip = (r > hi) || (r < lo);
        if (r > hi) begin
            res.value = hi[31:0];
        end else if (r < lo) begin
            res.value = lo[31:0];
        end else begin
            res.value = r[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/duc_scale_clip_if.sv
// rtl/duc_scale_clip_if.sv - stream handshake bundle used for the scaler input and output
interface duc_scale_clip_if #(
    parameter int W = 48
);
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tvalid;
    logic         tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/duc_scale_clip_lane.sv
// rtl/duc_scale_clip_lane.sv - one signed lane: S1 multiply register, S2 round/clip register
module duc_scale_clip_lane
    import duc_pkg::*;
#(
    parameter int WIDTH_IN  = 24,
    parameter int WIDTH_OUT = 16,
    parameter int SCALE_W   = 18
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic signed [WIDTH_IN-1:0]  din,
    input  logic signed [SCALE_W-1:0]   scale,
    output logic signed [WIDTH_OUT-1:0] dout,
    output logic                        clip
);

    localparam int PW    = WIDTH_IN + SCALE_W;
    localparam int SHIFT = SCALE_FRAC_BITS + WIDTH_IN - WIDTH_OUT;

    logic signed [PW-1:0] prod;
    sat_t                 sr;
    logic                 unused_sat_hi;

    always_comb begin
        sr = sat_round(64'(prod), SHIFT, WIDTH_OUT);
    end

    // Saturation already confined the value to WIDTH_OUT bits.
    assign unused_sat_hi = ^sr.value[31:WIDTH_OUT];

    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
            dout <= '0;
            clip <= 1'b0;
        end else if (en) begin
            prod <= PW'(din) * PW'(scale);
            dout <= sr.value[WIDTH_OUT-1:0];
            clip <= sr.clip;
        end
    end

endmodule

// File: rtl/duc_scale_clip.sv
// rtl/duc_scale_clip.sv - DUC output stage: 3-stage scale/round/clip stream with packet-aligned scale updates
module duc_scale_clip
    import duc_pkg::*;
#(
    parameter int                 WIDTH_IN      = 24,
    parameter int                 WIDTH_OUT     = 16,
    parameter int                 SCALE_W       = 18,
    parameter logic [SCALE_W-1:0] SCALE_DEFAULT = SCALE_W'(SCALE_UNITY)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               set_stb,
    input  logic [SCALE_W-1:0] set_data,
    input  logic               clear_clip,
    duc_scale_clip_if.slave    i,
    duc_scale_clip_if.master   o,
    output logic [SCALE_W-1:0] scale_active,
    output logic [15:0]        clip_count
);

    logic                        en;
    logic                        accept;
    logic                        pipe_empty;
    logic                        v0, v1, v2;
    logic                        l0, l1, l2;
    logic signed [WIDTH_IN-1:0]  s0_i, s0_q;
    logic signed [SCALE_W-1:0]   s0_scale;
    logic signed [WIDTH_OUT-1:0] out_i, out_q;
    logic                        clip_i, clip_q;
    logic                        sop;
    logic [SCALE_W-1:0]          pending_scale;
    logic [SCALE_W-1:0]          beat_scale;
    logic                        apply;
    scale_state_t                sc_state, sc_next;

    // One global advance: every stage moves whenever the output slot is free.
    assign en         = ~v2 | o.tready;
    assign i.tready   = en;
    assign accept     = i.tvalid & en;
    assign pipe_empty = ~(v0 | v1 | v2);

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_state <= SC_IDLE;
        end else begin
            sc_state <= sc_next;
        end
    end

    // A pending scale is only committed at a packet start, either with the
    // first beat itself or straight away while nothing is in flight.
    always_comb begin
        sc_next    = sc_state;
        apply      = 1'b0;
        beat_scale = scale_active;
        if (sc_state == SC_PENDING && sop) begin
            beat_scale = pending_scale;
            apply      = accept | pipe_empty;
        end
        if (set_stb) begin
            sc_next = SC_PENDING;
        end else if (apply) begin
            sc_next = SC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_scale <= SCALE_DEFAULT;
            scale_active  <= SCALE_DEFAULT;
            sop           <= 1'b1;
        end else begin
            if (set_stb) begin
                pending_scale <= set_data;
            end
            if (apply) begin
                scale_active <= pending_scale;
            end
            if (accept) begin
                sop <= i.tlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            l0       <= 1'b0;
            l1       <= 1'b0;
            l2       <= 1'b0;
            s0_i     <= '0;
            s0_q     <= '0;
            s0_scale <= '0;
        end else if (en) begin
            v0       <= i.tvalid;
            v1       <= v0;
            v2       <= v1;
            l0       <= i.tvalid & i.tlast;
            l1       <= l0;
            l2       <= l1;
            s0_i     <= i.tdata[2*WIDTH_IN-1:WIDTH_IN];
            s0_q     <= i.tdata[WIDTH_IN-1:0];
            s0_scale <= beat_scale;
        end
    end

    duc_scale_clip_lane #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .SCALE_W   (SCALE_W)
    ) u_lane_i (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .din   (s0_i),
        .scale (s0_scale),
        .dout  (out_i),
        .clip  (clip_i)
    );

    duc_scale_clip_lane #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .SCALE_W   (SCALE_W)
    ) u_lane_q (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .din   (s0_q),
        .scale (s0_scale),
        .dout  (out_q),
        .clip  (clip_q)
    );

    assign o.tdata  = {out_i, out_q};
    assign o.tlast  = l2;
    assign o.tvalid = v2;

    // Counts beats actually delivered, so a stalled clipped beat counts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count <= '0;
        end else if (clear_clip) begin
            clip_count <= '0;
        end else if (v2 && o.tready && (clip_i || clip_q) && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end

endmodule
